// File: rtl/param_digital_lock.sv
// param_digital_lock: parametrised code lock with press edge detection,
// failed-attempt lockout, automatic relock and a reprogrammable code.
module param_digital_lock #(
  parameter int BTN_W       = 4,
  parameter int CODE_LEN    = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 1000,
  parameter int OPEN_CYC    = 500,
  parameter logic [CODE_LEN*BTN_W-1:0] DEFAULT_CODE = 16'h1284
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BTN_W-1:0]                button,
  input  logic                            prog_en,
  input  logic                            relock,
  output logic                            open,
  output logic                            lockout,
  output logic [$clog2(CODE_LEN+1)-1:0]   progress,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
  output logic                            code_updated
);

  localparam int PW   = $clog2(CODE_LEN + 1);
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int TMAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = CODE_LEN * BTN_W;

  typedef enum logic [1:0] {ST_ENTRY, ST_OPEN, ST_PROG, ST_LOCKOUT} state_t;

  state_t          state_q, state_d;
  logic            any_q;
  logic [PW-1:0]   progress_q, progress_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic            err_q, err_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [CW-1:0]   code_q, code_d;
  logic [CW-1:0]   shadow_q, shadow_d;
  logic            open_q, lockout_q, upd_q, upd_d;

  logic            press;
  logic            last;
  logic            mismatch;
  logic            expired;

  assign press    = (button != '0) && !any_q;
  assign last     = (int'(progress_q) == CODE_LEN - 1);
  assign mismatch = (button != code_q[int'(progress_q)*BTN_W +: BTN_W]);
  assign expired  = (tmr_q == '0);

  // Next-state, counter and code-storage decisions for one cycle.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d    = state_q;
    progress_d = progress_q;
    fail_d     = fail_q;
    err_d      = err_q;
    tmr_d      = tmr_q;
    code_d     = code_q;
    shadow_d   = shadow_q;
    upd_d      = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        if (press) begin
          if (last) begin
            progress_d = '0;
            err_d      = 1'b0;
            if (!(err_q || mismatch)) begin
              state_d = ST_OPEN;
              fail_d  = '0;
              tmr_d   = TW'(OPEN_CYC - 1);
            end else if (int'(fail_q) + 1 < MAX_FAIL) begin
              fail_d = fail_q + FW'(1);
            end else begin
              state_d = ST_LOCKOUT;
              fail_d  = FW'(MAX_FAIL);
              tmr_d   = TW'(LOCKOUT_CYC - 1);
            end
          end else begin
            progress_d = progress_q + PW'(1);
            err_d      = err_q || mismatch;
          end
        end
      end

      ST_OPEN: begin
        // Relock or expiry wins over a same-cycle press, which is dropped.
        if (relock || expired) begin
          state_d    = ST_ENTRY;
          progress_d = '0;
          tmr_d      = '0;
        end else begin
          tmr_d = tmr_q - TW'(1);
          if (press && prog_en) begin
            shadow_d[0 +: BTN_W] = button;
            if (CODE_LEN == 1) begin
              code_d = shadow_d;
              upd_d  = 1'b1;
              tmr_d  = TW'(OPEN_CYC - 1);
            end else begin
              state_d    = ST_PROG;
              progress_d = PW'(1);
            end
          end
        end
      end

      ST_PROG: begin
        if (relock || expired) begin
          state_d    = ST_ENTRY;
          progress_d = '0;
          tmr_d      = '0;
        end else begin
          tmr_d = tmr_q - TW'(1);
          if (press) begin
            shadow_d[int'(progress_q)*BTN_W +: BTN_W] = button;
            if (last) begin
              code_d     = shadow_d;
              upd_d      = 1'b1;
              state_d    = ST_OPEN;
              progress_d = '0;
              tmr_d      = TW'(OPEN_CYC - 1);
            end else begin
              progress_d = progress_q + PW'(1);
            end
          end
        end
      end

      ST_LOCKOUT: begin
        if (expired) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end

      default: state_d = ST_ENTRY;
    endcase
  end

  // State, counters, stored code and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q    <= ST_ENTRY;
      any_q      <= 1'b1;
      progress_q <= '0;
      fail_q     <= '0;
      err_q      <= 1'b0;
      tmr_q      <= '0;
      code_q     <= DEFAULT_CODE;
      open_q     <= 1'b0;
      lockout_q  <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      any_q      <= (button != '0);
      progress_q <= progress_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
      tmr_q      <= tmr_d;
      code_q     <= code_d;
      open_q     <= (state_d == ST_OPEN) || (state_d == ST_PROG);
      lockout_q  <= (state_d == ST_LOCKOUT);
      upd_q      <= upd_d;
    end
  end

  // Shadow code being programmed; every digit is rewritten before a commit.
  always_ff @(posedge clk) begin
    // NOTE: the shadow register needs no reset since it is never read before being fully written.
    shadow_q <= shadow_d;
  end

  assign open         = open_q;
  assign lockout      = lockout_q;
  assign progress     = progress_q;
  assign fail_cnt     = fail_q;
  assign code_updated = upd_q;

endmodule

// File: tb/tb_param_digital_lock.sv
// Self-checking bench for param_digital_lock: directed stimulus, an
// event-level reference model compared every cycle, and literal spot checks.
module tb_param_digital_lock;

  localparam int BTN_W       = 4;
  localparam int CODE_LEN    = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 1000;
  localparam int OPEN_CYC    = 500;
  localparam logic [CODE_LEN*BTN_W-1:0] DEF_CODE = 16'h1284;
  localparam int PW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [BTN_W-1:0] button = '0;
  logic             prog_en = 1'b0;
  logic             relock = 1'b0;
  logic             open, lockout, code_updated;
  logic [PW-1:0]    progress;
  logic [FW-1:0]    fail_cnt;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;
  int upd_seen = 0;

  param_digital_lock #(
    .BTN_W(BTN_W), .CODE_LEN(CODE_LEN), .MAX_FAIL(MAX_FAIL),
    .LOCKOUT_CYC(LOCKOUT_CYC), .OPEN_CYC(OPEN_CYC), .DEFAULT_CODE(DEF_CODE)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .prog_en(prog_en), .relock(relock),
    .open(open), .lockout(lockout), .progress(progress), .fail_cnt(fail_cnt),
    .code_updated(code_updated)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // Reference model: remaining-cycle counters and digit queues.
  int               m_open_left = 0;
  int               m_lock_left = 0;
  bit               m_in_prog = 1'b0;
  int               m_fails = 0;
  bit               m_upd = 1'b0;
  bit               m_prev_any = 1'b1;
  logic [BTN_W-1:0] m_code [CODE_LEN];
  logic [BTN_W-1:0] m_entered[$];
  logic [BTN_W-1:0] m_buf[$];

  task automatic model_reset();
    logic [CODE_LEN*BTN_W-1:0] dc;
    dc = DEF_CODE;
    for (int i = 0; i < CODE_LEN; i++) m_code[i] = dc[i*BTN_W +: BTN_W];
    m_open_left = 0; m_lock_left = 0; m_in_prog = 0; m_fails = 0; m_upd = 0;
    m_prev_any = 1'b1;
    m_entered.delete(); m_buf.delete();
  endtask

  always @(posedge clk) begin
    bit pr;
    bit ok;
    pr = (button != 0) && !m_prev_any;
    m_prev_any = (button != 0);
    m_upd = 1'b0;
    if (rst) begin
      model_reset();
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_open_left > 0) begin
      m_open_left--;
      if (relock) m_open_left = 0;
      if (m_open_left == 0) begin
        m_in_prog = 0;
        m_buf.delete();
      end else if (pr && (m_in_prog || prog_en)) begin
        m_buf.push_back(button);
        m_in_prog = 1;
        if (m_buf.size() == CODE_LEN) begin
          for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_buf[i];
          m_buf.delete();
          m_in_prog = 0;
          m_upd = 1;
          m_open_left = OPEN_CYC;
        end
      end
    end else if (pr) begin
      m_entered.push_back(button);
      if (m_entered.size() == CODE_LEN) begin
        ok = 1;
        for (int i = 0; i < CODE_LEN; i++) if (m_entered[i] != m_code[i]) ok = 0;
        m_entered.delete();
        if (ok) begin
          m_open_left = OPEN_CYC;
          m_fails = 0;
        end else begin
          m_fails++;
          if (m_fails == MAX_FAIL) m_lock_left = LOCKOUT_CYC;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    int mp;
    if (started) begin
      mp = (m_open_left > 0) ? m_buf.size() : m_entered.size();
      check("open",         int'(open),         int'(m_open_left > 0));
      check("lockout",      int'(lockout),      int'(m_lock_left > 0));
      check("progress",     int'(progress),     mp);
      check("fail_cnt",     int'(fail_cnt),     m_fails);
      check("code_updated", int'(code_updated), int'(m_upd));
    end
    if (code_updated) upd_seen++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_digit(input logic [BTN_W-1:0] d);
    button = d;
    @(negedge clk);
    button = '0;
    @(negedge clk);
  endtask

  task automatic enter4(input logic [BTN_W-1:0] a, b, c, d);
    press_digit(a); press_digit(b); press_digit(c); press_digit(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();
    started = 1'b1;
    check("rst_open", int'(open), 0);
    check("rst_progress", int'(progress), 0);
    check("rst_fail", int'(fail_cnt), 0);

    // Default unlock and open window length.
    enter4(4'd4, 4'd8, 4'd2, 4'd1);
    check("unlock_open", int'(open), 1);
    check("unlock_progress", int'(progress), 0);
    idle(OPEN_CYC - 2);
    check("window_last_cycle", int'(open), 1);
    idle(1);
    check("window_closed", int'(open), 0);

    // Held button and glitch while held.
    button = 4'b0100; idle(10);
    button = 4'b0110; idle(5);
    button = '0; idle(2);
    check("held_progress", int'(progress), 1);
    button = 4'b0100;
    rst = 1'b1; idle(1); rst = 1'b0;
    idle(4);
    button = '0; idle(2);
    check("held_through_rst", int'(progress), 0);

    // Silent error: wrong first digit.
    press_digit(4'd2); press_digit(4'd8); press_digit(4'd2);
    check("silent_progress3", int'(progress), 3);
    press_digit(4'd1);
    check("silent_open", int'(open), 0);
    check("silent_fail", int'(fail_cnt), 1);

    // Two more failures lead to lockout.
    enter4(4'd1, 4'd1, 4'd1, 4'd1);
    check("fail2", int'(fail_cnt), 2);
    enter4(4'd8, 4'd4, 4'd2, 4'd1);
    check("lockout_on", int'(lockout), 1);
    check("lockout_fail", int'(fail_cnt), MAX_FAIL);
    enter4(4'd4, 4'd8, 4'd2, 4'd1);
    check("lockout_ignores", int'(open), 0);
    idle(LOCKOUT_CYC - 10);
    check("lockout_last", int'(lockout), 1);
    idle(1);
    check("lockout_off", int'(lockout), 0);
    check("lockout_fail_clr", int'(fail_cnt), 0);
    enter4(4'd4, 4'd8, 4'd2, 4'd1);
    check("after_lockout_open", int'(open), 1);

    // Reprogram to 1,1,2,2.
    upd_seen = 0;
    prog_en = 1'b1;
    enter4(4'd1, 4'd1, 4'd2, 4'd2);
    prog_en = 1'b0;
    check("prog_upd_once", upd_seen, 1);
    check("prog_open", int'(open), 1);
    relock = 1'b1; idle(1); relock = 1'b0; idle(1);
    check("relock_closed", int'(open), 0);
    enter4(4'd1, 4'd1, 4'd2, 4'd2);
    check("new_code_opens", int'(open), 1);
    relock = 1'b1; idle(1); relock = 1'b0; idle(1);
    enter4(4'd4, 4'd8, 4'd2, 4'd1);
    check("old_code_fails", int'(open), 0);
    check("old_code_fail_cnt", int'(fail_cnt), 1);
    do_reset();
    enter4(4'd4, 4'd8, 4'd2, 4'd1);
    check("default_restored", int'(open), 1);

    // Abort by relock coinciding with a press.
    prog_en = 1'b1;
    press_digit(4'd1); press_digit(4'd2);
    check("prog_two_digits", int'(progress), 2);
    button = 4'd4; relock = 1'b1;
    @(negedge clk);
    button = '0; relock = 1'b0; prog_en = 1'b0;
    @(negedge clk);
    check("abort_relock_open", int'(open), 0);
    check("abort_relock_progress", int'(progress), 0);
    enter4(4'd4, 4'd8, 4'd2, 4'd1);
    check("abort_code_kept", int'(open), 1);

    // Abort by window expiry coinciding with a press.
    prog_en = 1'b1;
    press_digit(4'd1); press_digit(4'd2);
    idle(OPEN_CYC - 6);
    check("expiry_still_open", int'(open), 1);
    button = 4'd4;
    @(negedge clk);
    button = '0; prog_en = 1'b0;
    check("abort_expiry_open", int'(open), 0);
    check("abort_expiry_progress", int'(progress), 0);
    @(negedge clk);
    enter4(4'd4, 4'd8, 4'd2, 4'd1);
    check("expiry_code_kept", int'(open), 1);

    idle(3);
    started = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
